// File: rtl/seq_pkg.sv
// Shared types and default sizes for the instruction sequencer.
package seq_pkg;

    localparam int DEF_DEPTH       = 8;
    localparam int DEF_DIR_W       = 2;
    localparam int DEF_TORQUE_W    = 3;
    localparam int DEF_STEP_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [DEF_TORQUE_W-1:0] torque;
        logic [DEF_DIR_W-1:0]    dir;
    } instr_t;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that times one playback step; load wins over hold,
// and the count saturates at zero so o_expired stays high until reloaded.
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_hold,
    output logic o_expired
);

    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= RELOAD;
        end else if (!i_hold && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/instruction_sequencer.sv
// Stores a program of motor instructions and replays it one step per STEP_CYCLES.
// Optional loop-back on the last step is enabled by defining SEQ_LOOP_EN.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DIR_W       = DEF_DIR_W,
    parameter int TORQUE_W    = DEF_TORQUE_W,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_save,
    input  logic                         i_delete,
    input  logic                         i_clear,
    input  logic                         i_execute,
    input  logic                         i_abort,
    input  logic                         i_loop,
    input  logic [DIR_W+TORQUE_W-1:0]    i_instr_in,
    output logic [DIR_W+TORQUE_W-1:0]    o_instr_out,
    output logic                         o_active,
    output logic                         o_step_start,
    output logic [1:0]                   o_state,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH)-1:0]     o_index,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int W  = DIR_W + TORQUE_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    seq_state_e    r_state;
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_index;
    logic [W-1:0]  r_instr_out;
    logic          r_active;
    logic          r_step_start;
    logic          r_empty;
    logic          r_full;

    logic          w_expired;
    logic          w_load;
    logic          w_hold;
    logic          w_last;
    logic          w_loop;
    logic          w_wr;
    logic [CW-1:0] w_count_next;

`ifdef SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    logic w_unused_loop;
    assign w_unused_loop = i_loop;
    assign w_loop        = 1'b0;
`endif

    assign w_last = (CW'(r_index) == (r_count - CW'(1)));

    // Program edits only happen in IDLE; clear beats save/delete, and save+delete cancel.
    always_comb begin
        w_count_next = r_count;
        w_wr         = 1'b0;
        if (r_state == IDLE) begin
            if (i_clear) begin
                w_count_next = '0;
            end else if (i_save && !i_delete && !r_full) begin
                w_count_next = r_count + CW'(1);
                w_wr         = 1'b1;
            end else if (i_delete && !i_save && !r_empty) begin
                w_count_next = r_count - CW'(1);
            end
        end
    end

    assign w_hold = (r_state != RUN);
    assign w_load = ((r_state == IDLE) && i_execute && !i_abort && !r_empty) ||
                    ((r_state == RUN) && !i_abort && !i_execute && w_expired &&
                     (!w_last || w_loop));

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_load),
        .i_hold    (w_hold),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (w_wr && !i_rst) begin
            r_mem[r_count[IW-1:0]] <= i_instr_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_index      <= '0;
            r_instr_out  <= '0;
            r_active     <= 1'b0;
            r_step_start <= 1'b0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_empty      <= (w_count_next == '0);
            r_full       <= (w_count_next == CW'(DEPTH));
            r_step_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_execute && !i_abort && !r_empty) begin
                        r_state      <= RUN;
                        r_index      <= '0;
                        r_instr_out  <= r_mem[0];
                        r_active     <= 1'b1;
                        r_step_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_state     <= IDLE;
                        r_index     <= '0;
                        r_instr_out <= '0;
                        r_active    <= 1'b0;
                    end else if (i_execute) begin
                        r_state     <= PAUSE;
                        r_instr_out <= '0;
                        r_active    <= 1'b0;
                    end else if (w_expired) begin
                        if (!w_last) begin
                            r_index      <= r_index + IW'(1);
                            r_instr_out  <= r_mem[r_index + IW'(1)];
                            r_step_start <= 1'b1;
                        end else if (w_loop) begin
                            r_index      <= '0;
                            r_instr_out  <= r_mem[0];
                            r_step_start <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_index     <= '0;
                            r_instr_out <= '0;
                            r_active    <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_index <= '0;
                    end else if (i_execute) begin
                        // Resume with the frozen remaining time; not a new step.
                        r_state     <= RUN;
                        r_instr_out <= r_mem[r_index];
                        r_active    <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_index     <= '0;
                    r_instr_out <= '0;
                    r_active    <= 1'b0;
                end
            endcase
        end
    end

    assign o_instr_out  = r_instr_out;
    assign o_active     = r_active;
    assign o_step_start = r_step_start;
    assign o_state      = r_state;
    assign o_count      = r_count;
    assign o_index      = r_index;
    assign o_empty      = r_empty;
    assign o_full       = r_full;

endmodule
